can_bit_destuff: RTL and testbench

CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

---
 rtl/can_bit_destuff.sv | 273 +++++++++++++++++++++++++++
 tb/tb_can_bit_destuff.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_destuff.sv
// CAN receive-side bit destuffer and field tracker.
// Takes sampled bus bits (one bit_valid strobe per bit time), waits for bus
// idle, accepts SOF, removes stuff bits, tracks the base-format fields up to
// the CRC delimiter and flags stuff and form violations. All outputs are
// registered and appear one clock after the bit_valid that produced them.
module can_bit_destuff #(
    parameter int IDLE_BITS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        dout,
    output logic        dout_valid,
    output logic        crc_cover,
    output logic [14:0] rx_crc,
    output logic        rx_crc_valid,
    output logic [3:0]  dlc,
    output logic        stuff_err,
    output logic        form_err,
    output logic        busy
);

    localparam int ICW = $clog2(IDLE_BITS + 1);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_BITS);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        ARB       = 3'd2,
        CTRL      = 3'd3,
        DATA      = 3'd4,
        CRC       = 3'd5,
        DELIM     = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [2:0]      run_len_q, run_len_d;
    logic            run_val_q, run_val_d;
    logic [6:0]      field_cnt_q, field_cnt_d;
    logic [6:0]      data_len_q, data_len_d;
    logic            rtr_q, rtr_d;
    logic [3:0]      dlc_q, dlc_d;
    logic [14:0]     rx_crc_q, rx_crc_d;
    logic            dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            crc_cover_q, crc_cover_d;
    logic            rx_crc_valid_q, rx_crc_valid_d;
    logic            stuff_err_q, stuff_err_d;
    logic            form_err_q, form_err_d;
    logic            busy_q, busy_d;

    logic [3:0]      dlc_next_s;
    logic [6:0]      data_len_s;

    // DLC as it will look once the current bit is shifted in, and the data length it implies
    always_comb begin
        dlc_next_s = {dlc_q[2:0], bit_in};
        if (rtr_q) begin
            data_len_s = 7'd0;
        end else if (dlc_next_s[3]) begin
            data_len_s = 7'd64;
        end else begin
            data_len_s = {1'b0, dlc_next_s[2:0], 3'b000};
        end
    end

    // Next-state, destuffing and field tracking; pulses default low every cycle
    always_comb begin
        state_d        = state_q;
        idle_cnt_d     = idle_cnt_q;
        run_len_d      = run_len_q;
        run_val_d      = run_val_q;
        field_cnt_d    = field_cnt_q;
        data_len_d     = data_len_q;
        rtr_d          = rtr_q;
        dlc_d          = dlc_q;
        rx_crc_d       = rx_crc_q;
        dout_d         = dout_q;
        dout_valid_d   = 1'b0;
        crc_cover_d    = crc_cover_q;
        rx_crc_valid_d = 1'b0;
        stuff_err_d    = 1'b0;
        form_err_d     = 1'b0;

        if (bit_valid) begin
            case (state_q)
                WAIT_IDLE: begin
                    if (bit_in) begin
                        idle_cnt_d = idle_cnt_q + ICW'(1);
                        if (idle_cnt_d == IDLE_MAX) begin
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                IDLE: begin
                    if (!bit_in) begin
                        // SOF: first destuffed bit, opens a dominant run
                        state_d      = ARB;
                        run_len_d    = 3'd1;
                        run_val_d    = 1'b0;
                        field_cnt_d  = 7'd1;
                        rtr_d        = 1'b0;
                        dlc_d        = 4'd0;
                        rx_crc_d     = 15'd0;
                        dout_d       = 1'b0;
                        dout_valid_d = 1'b1;
                        crc_cover_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARB, CTRL, DATA, CRC: begin
                    if (run_len_q == 3'd5) begin
                        // Stuff slot: must be the opposite of the run
                        if (bit_in == run_val_q) begin
                            stuff_err_d = 1'b1;
                            state_d     = WAIT_IDLE;
                            idle_cnt_d  = '0;
                            run_len_d   = 3'd0;
                        end else begin
                            run_len_d = 3'd1;
                            run_val_d = bit_in;
                        end
                    end else begin
                        if (bit_in == run_val_q) begin
                            run_len_d = run_len_q + 3'd1;
                        end else begin
                            run_len_d = 3'd1;
                            run_val_d = bit_in;
                        end
                        dout_d = bit_in;
                        case (state_q)
                            ARB: begin
                                dout_valid_d = 1'b1;
                                crc_cover_d  = 1'b1;
                                if (field_cnt_q == 7'd12) begin
                                    rtr_d       = bit_in;
                                    state_d     = CTRL;
                                    field_cnt_d = 7'd0;
                                end else begin
                                    field_cnt_d = field_cnt_q + 7'd1;
                                end
                            end
                            CTRL: begin
                                if ((field_cnt_q == 7'd0) && bit_in) begin
                                    // Extended-format IDE is not supported here
                                    form_err_d = 1'b1;
                                    state_d    = WAIT_IDLE;
                                    idle_cnt_d = '0;
                                    run_len_d  = 3'd0;
                                end else begin
                                    dout_valid_d = 1'b1;
                                    crc_cover_d  = 1'b1;
                                    if (field_cnt_q >= 7'd2) begin
                                        dlc_d = dlc_next_s;
                                    end else begin
                                        dlc_d = dlc_q;
                                    end
                                    if (field_cnt_q == 7'd5) begin
                                        data_len_d  = data_len_s;
                                        field_cnt_d = 7'd0;
                                        if (data_len_s == 7'd0) begin
                                            state_d = CRC;
                                        end else begin
                                            state_d = DATA;
                                        end
                                    end else begin
                                        field_cnt_d = field_cnt_q + 7'd1;
                                    end
                                end
                            end
                            DATA: begin
                                dout_valid_d = 1'b1;
                                crc_cover_d  = 1'b1;
                                if (field_cnt_q == (data_len_q - 7'd1)) begin
                                    state_d     = CRC;
                                    field_cnt_d = 7'd0;
                                end else begin
                                    field_cnt_d = field_cnt_q + 7'd1;
                                end
                            end
                            default: begin
                                // CRC field: shifted MSB first, not CRC-covered
                                dout_valid_d = 1'b1;
                                crc_cover_d  = 1'b0;
                                rx_crc_d     = {rx_crc_q[13:0], bit_in};
                                if (field_cnt_q == 7'd14) begin
                                    rx_crc_valid_d = 1'b1;
                                    state_d        = DELIM;
                                    field_cnt_d    = 7'd0;
                                end else begin
                                    field_cnt_d = field_cnt_q + 7'd1;
                                end
                            end
                        endcase
                    end
                end
                DELIM: begin
                    // Delimiter is never stuffed; dominant is a form violation
                    form_err_d = ~bit_in;
                    state_d    = WAIT_IDLE;
                    idle_cnt_d = '0;
                    run_len_d  = 3'd0;
                end
                default: begin
                    state_d    = WAIT_IDLE;
                    idle_cnt_d = '0;
                    run_len_d  = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != WAIT_IDLE) && (state_d != IDLE);
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_IDLE;
            idle_cnt_q     <= '0;
            run_len_q      <= 3'd0;
            run_val_q      <= 1'b0;
            field_cnt_q    <= 7'd0;
            data_len_q     <= 7'd0;
            rtr_q          <= 1'b0;
            dlc_q          <= 4'd0;
            rx_crc_q       <= 15'd0;
            dout_q         <= 1'b1;
            dout_valid_q   <= 1'b0;
            crc_cover_q    <= 1'b0;
            rx_crc_valid_q <= 1'b0;
            stuff_err_q    <= 1'b0;
            form_err_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_cnt_q     <= idle_cnt_d;
            run_len_q      <= run_len_d;
            run_val_q      <= run_val_d;
            field_cnt_q    <= field_cnt_d;
            data_len_q     <= data_len_d;
            rtr_q          <= rtr_d;
            dlc_q          <= dlc_d;
            rx_crc_q       <= rx_crc_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            crc_cover_q    <= crc_cover_d;
            rx_crc_valid_q <= rx_crc_valid_d;
            stuff_err_q    <= stuff_err_d;
            form_err_q     <= form_err_d;
            busy_q         <= busy_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign crc_cover    = crc_cover_q;
    assign rx_crc       = rx_crc_q;
    assign rx_crc_valid = rx_crc_valid_q;
    assign dlc          = dlc_q;
    assign stuff_err    = stuff_err_q;
    assign form_err     = form_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed bench for can_bit_destuff: builds base-format frames (with a real
// CRC-15), stuffs them, drives them bit by bit and checks the destuffed
// stream, field outputs and error pulses.
module tb_can_bit_destuff;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_valid;
    logic        dout;
    logic        dout_valid;
    logic        crc_cover;
    logic [14:0] rx_crc;
    logic        rx_crc_valid;
    logic [3:0]  dlc;
    logic        stuff_err;
    logic        form_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Observed output stream, recorded on the falling edge
    bit          dq[$];
    bit          cq[$];
    int          se_cnt = 0;
    int          fe_cnt = 0;
    int          rcv_cnt = 0;
    logic [14:0] rcv_val = 15'd0;

    // Expected frame (unstuffed SOF..CRC), stuffed stream, and its attributes
    bit          fr[$];
    bit          st[$];
    int          cov_len;
    logic [14:0] crc_exp;
    logic [3:0]  exp_dlc;

    can_bit_destuff #(.IDLE_BITS(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .crc_cover   (crc_cover),
        .rx_crc      (rx_crc),
        .rx_crc_valid(rx_crc_valid),
        .dlc         (dlc),
        .stuff_err   (stuff_err),
        .form_err    (form_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Record destuffed bits and count pulses away from the active edge
    always @(negedge clk) begin
        if (dout_valid) begin
            dq.push_back(dout);
            cq.push_back(crc_cover);
        end
        if (stuff_err)    se_cnt  <= se_cnt + 1;
        if (form_err)     fe_cnt  <= fe_cnt + 1;
        if (rx_crc_valid) begin
            rcv_cnt <= rcv_cnt + 1;
            rcv_val <= rx_crc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {6'd0, dout, dout_valid, crc_cover, rx_crc_valid, stuff_err, form_err, busy, dlc, rx_crc},
                 {6'd0, 1'b1, 6'b000000, 4'd0, 15'd0});
    endtask

    // One bit time: optional idle gap, then a one-cycle strobe; returns #1 after the sampling edge
    task automatic send(input bit b, input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        repeat (g) @(negedge clk);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic build(input logic [10:0] id, input bit rtr, input logic [3:0] d, input logic [63:0] data);
        int n;
        logic [14:0] c;
        bit nxt;
        fr.delete();
        fr.push_back(1'b0);
        for (int i = 10; i >= 0; i--) fr.push_back(id[i]);
        fr.push_back(rtr);
        fr.push_back(1'b0);
        fr.push_back(1'b0);
        for (int i = 3; i >= 0; i--) fr.push_back(d[i]);
        n = rtr ? 0 : ((d > 4'd8) ? 64 : int'(d) * 8);
        for (int i = 0; i < n; i++) fr.push_back(data[63-i]);
        cov_len = fr.size();
        c = 15'd0;
        foreach (fr[i]) begin
            nxt = fr[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (nxt) c = c ^ 15'h4599;
        end
        crc_exp = c;
        exp_dlc = d;
        for (int i = 14; i >= 0; i--) fr.push_back(c[i]);
    endtask

    // Insert a complement bit after every 5 equal bits, up to the last frame bit
    task automatic do_stuff();
        bit v;
        int run;
        v = 1'b1;
        run = 0;
        st.delete();
        foreach (fr[i]) begin
            st.push_back(fr[i]);
            if (fr[i] == v) run++;
            else begin
                v = fr[i];
                run = 1;
            end
            if ((run == 5) && (i < fr.size() - 1)) begin
                st.push_back(~v);
                v = ~v;
                run = 1;
            end
        end
    endtask

    task automatic run_frame(input string tag, input int gmax, input bit delim);
        int bd, bse, bfe, brc, nmis, ncov;
        bd = dq.size(); bse = se_cnt; bfe = fe_cnt; brc = rcv_cnt;
        repeat (11) send(1'b1, gmax);
        foreach (st[i]) send(st[i], gmax);
        send(delim, gmax);
        chk({tag, " delim_form_err"}, form_err, {31'd0, ~delim});
        repeat (3) send(1'b1, 0);
        nmis = 0;
        ncov = 0;
        foreach (fr[i]) begin
            if (bd + i < dq.size()) begin
                if (dq[bd+i] !== fr[i]) nmis++;
                if (cq[bd+i] !== (i < cov_len)) ncov++;
            end
        end
        chk({tag, " n_dout"}, dq.size() - bd, fr.size());
        chk({tag, " bit_mismatches"}, nmis, 0);
        chk({tag, " cover_mismatches"}, ncov, 0);
        chk({tag, " rx_crc"}, rx_crc, crc_exp);
        chk({tag, " crc_valid_cnt"}, rcv_cnt - brc, 1);
        chk({tag, " crc_at_valid"}, rcv_val, crc_exp);
        chk({tag, " stuff_err_cnt"}, se_cnt - bse, 0);
        chk({tag, " form_err_cnt"}, fe_cnt - bfe, delim ? 0 : 1);
        chk({tag, " dlc"}, dlc, exp_dlc);
        chk({tag, " busy"}, busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Nominal frame: ID 0x123, DLC 1, data 0xAA (42 destuffed bits, 27 covered)
        build(11'h123, 1'b0, 4'd1, {8'hAA, 56'd0});
        do_stuff();
        run_frame("f1", 0, 1'b1);
        chk("f1 n_cover_bits", cov_len, 27);
        // Same frame with random gaps must give the identical stream
        run_frame("f1_gap", 5, 1'b1);

        // All-zero ID: heavy stuffing
        build(11'h000, 1'b0, 4'd0, 64'd0);
        do_stuff();
        chk("id0 stuff_at_6", st[5], 1'b1);
        run_frame("id0", 0, 1'b1);

        // Stuff bit sent with the wrong value
        repeat (11) send(1'b1, 0);
        repeat (5) send(1'b0, 0);
        chk("se_dout_before", dout_valid, 1'b1);
        send(1'b0, 0);
        chk("se_pulse", stuff_err, 1'b1);
        chk("se_no_dout", dout_valid, 1'b0);
        chk("se_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("se_pulse_one_cycle", stuff_err, 1'b0);
        repeat (5) send(1'b1, 0);
        send(1'b0, 0);
        chk("early_sof_busy", busy, 1'b0);
        chk("early_sof_dout", dout_valid, 1'b0);
        repeat (11) send(1'b1, 0);
        send(1'b0, 0);
        chk("late_sof_busy", busy, 1'b1);
        chk("late_sof_dout", {dout_valid, dout, crc_cover}, 3'b101);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("rst_after_sof");
        @(negedge clk);
        rst = 1'b0;

        // Remote frame: DLC 4 but no data field
        build(11'h0F0, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        do_stuff();
        run_frame("rtr", 0, 1'b1);
        chk("rtr n_cover_bits", cov_len, 19);

        // DLC 15 clamps to 64 data bits
        build(11'h5A5, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF);
        do_stuff();
        run_frame("dlc15", 0, 1'b1);
        chk("dlc15 n_cover_bits", cov_len, 83);

        // IDE recessive: form error on that bit
        build(11'h123, 1'b0, 4'd1, {8'hAA, 56'd0});
        fr[13] = 1'b1;
        while (fr.size() > 14) void'(fr.pop_back());
        do_stuff();
        repeat (11) send(1'b1, 0);
        foreach (st[i]) send(st[i], 0);
        chk("ide_form_err", form_err, 1'b1);
        chk("ide_no_dout", dout_valid, 1'b0);
        chk("ide_busy", busy, 1'b0);
        repeat (2) send(1'b1, 0);

        // Dominant delimiter after a good CRC
        build(11'h321, 1'b0, 4'd2, {16'hC35A, 48'd0});
        do_stuff();
        run_frame("ddelim", 0, 1'b0);

        // Reset in the middle of the data field
        build(11'h123, 1'b0, 4'd1, {8'hAA, 56'd0});
        do_stuff();
        repeat (11) send(1'b1, 0);
        for (int i = 0; i < 24; i++) send(st[i], 0);
        chk("mid_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, 0);
        chk("post_rst_sof_ignored", {busy, dout_valid, stuff_err, form_err}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
